uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_W, default 8, byte width matching uart_tx data_in.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_data  input  DATA_W  byte to queue.
REQ-006 SHALL have port wr_en  input  1  write strobe, one byte per cycle.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse on a write rejected because the FIFO is full.
REQ-011 SHALL have port tx_data  output  DATA_W  byte to uart_tx data_in.
REQ-012 SHALL have port tx_start  output  1  one-cycle start pulse to uart_tx start.
REQ-013 SHALL have port tx_busy  input  1  busy from uart_tx.

Function
REQ-014 SHALL implement a circular buffer with read and write pointers $clog2(DEPTH) bits wide that wrap from DEPTH-1 to 0, plus a separate occupancy counter.
REQ-015 SHALL accept a write when wr_en=1 and full=0; the byte is stored and count increments on the next edge.
REQ-016 SHALL drop a write when wr_en=1 and full=1, and SHALL pulse overflow for that cycle; contents are unchanged, even if a pop occurs in the same cycle.
REQ-017 SHALL decrement count by one on a pop; a simultaneous accepted write and pop SHALL leave count unchanged.
REQ-018 SHALL run a four-state drain FSM: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE -> START when empty=0 and tx_busy=0; on that transition the head byte is loaded into tx_data and popped.
REQ-020 START SHALL assert tx_start for exactly one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY -> WAIT_DONE when tx_busy=1.
REQ-022 WAIT_DONE -> IDLE when tx_busy=0.
REQ-023 SHALL hold tx_data stable from the START cycle until the return to IDLE.
REQ-024 Latency: a byte written at edge N into an empty FIFO with the FSM idle SHALL produce tx_start=1 in cycle N+2 (pop at edge N+1, pulse in the following cycle).
REQ-025 SHALL issue back-to-back bytes without intervening host action until the FIFO empties.
REQ-026 full, empty, count and tx_start SHALL be registered or decoded from registered state only; no combinational path from wr_en or tx_busy to outputs.

Reset
REQ-027 When rst=0, SHALL asynchronously clear the pointers and count, and force the FSM to IDLE, tx_start=0, tx_data=0, overflow=0, empty=1, full=0.
REQ-028 Reset mid-transfer SHALL discard all queued bytes; after release, no tx_start SHALL issue until a new write.
REQ-029 Memory array contents need no reset.

Structure
REQ-030 A shared package uart_pkg SHALL hold the FSM state enum (tx_fifo_state_t), CLOCK_FREQ=50_000_000 and BAUD_RATE=115200.
REQ-031 Storage and pointers SHALL form one sub-module, sync_fifo (DEPTH, DATA_W); uart_tx_fifo instantiates it and adds the drain FSM.

Verification
REQ-032 Bench SHALL instantiate uart_tx_fifo -> uart_tx -> uart_rx loopback at 50 MHz/115200 and check each rx_valid byte against the sent order.
REQ-033 Single write 8'h55 into an idle FIFO -> tx_start at cycle N+2; rx_data=8'h55 about 10 bit times (4340 clocks) later.
REQ-034 Burst-write 8'h55, 8'hA5, 8'h0F, 8'hFF on consecutive cycles -> count peaks at 3 or 4; received in the same order; empty=1 after the last start.
REQ-035 With DEPTH=16, write 17 bytes while tx_busy is held high by a stub -> full=1 after 16; overflow pulses once on write 17; count=16.
REQ-036 Assert rst=0 while byte 2 of 4 is transmitting -> count=0, empty=1, FSM IDLE, no further tx_start; next write of 8'h3C transmits normally.
REQ-037 Fill to DEPTH, drain fully, refill -> pointers wrap past DEPTH-1 and data order is preserved across the wrap.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit-drain FSM state type
package uart_pkg;

    localparam int CLOCK_FREQ   = 50_000_000;
    localparam int BAUD_RATE    = 115200;
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-buffer byte FIFO with occupancy counter
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DATA_W-1:0]      wr_data_i,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_accept;
    logic              rd_accept;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // A write into a full FIFO is refused even when a pop frees a slot this cycle.
    assign wr_accept  = wr_en_i & ~full_o;
    assign rd_accept  = rd_en_i & ~empty_o;
    assign overflow_o = wr_en_i & full_o;

    // DEPTH is a power of two, so pointer increments wrap DEPTH-1 -> 0 naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that drains itself into a uart_tx one byte at a time
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy
);

    tx_fifo_state_t    state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] head_data;
    logic              pop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .rd_en_i    (pop),
        .rd_data_o  (head_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow)
    );

    // The head byte is captured as it is popped, so tx_data stays put for the whole transfer.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d   = TX_START;
                    tx_data_d = head_data;
                    pop       = 1'b1;
                end
            end
            TX_START: begin
                state_d = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= TX_IDLE;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_start = (state_q == TX_START);
    assign tx_data  = tx_data_q;

endmodule
